// File: rtl/gpio_bank_if.sv
// Word-addressed register bus between a bus master and a GPIO bank.
interface gpio_bank_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;
  logic              rd_valid;

  modport master (
    output addr, we, re, wd,
    input  rd, rd_valid
  );

  modport slave (
    input  addr, we, re, wd,
    output rd, rd_valid
  );
endinterface : gpio_bank_if

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: N_IN synchronised input ports, N_OUT bus-writable output registers,
// sticky rising-edge capture with a maskable interrupt on input port 0, and a
// registered read-data path with a one-cycle valid strobe.
module gpio_bank_ctrl #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  gpio_bank_if.slave              bus,
  input  logic [N_IN*DATA_W-1:0]  gpi,
  output logic [N_OUT*DATA_W-1:0] gpo,
  output logic                    irq,
  output logic                    addr_err
);

  // Register map: inputs, then outputs, then EDGE and IEN; everything above is unmapped.
  localparam int EDGE_ADDR = N_IN + N_OUT;
  localparam int IEN_ADDR  = N_IN + N_OUT + 1;
  localparam int N_MAPPED  = N_IN + N_OUT + 2;

  // The map has to fit in the address space, and the bank needs at least one port each way.
  if (N_MAPPED > (2 ** ADDR_W)) begin : g_addr_too_narrow
    $error("gpio_bank_ctrl: ADDR_W=%0d cannot hold %0d registers", ADDR_W, N_MAPPED);
  end
  if (N_IN < 1 || N_OUT < 1) begin : g_bad_port_count
    $error("gpio_bank_ctrl: N_IN and N_OUT must both be >= 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] s1_q   [N_IN];
  logic [DATA_W-1:0] s1_d   [N_IN];
  logic [DATA_W-1:0] s2_q   [N_IN];
  logic [DATA_W-1:0] s2_d   [N_IN];
  logic [DATA_W-1:0] s3_q;
  logic [DATA_W-1:0] s3_d;
  logic [1:0]        prime_q;
  logic [1:0]        prime_d;
  logic [DATA_W-1:0] gpo_q  [N_OUT];
  logic [DATA_W-1:0] gpo_d  [N_OUT];
  logic [DATA_W-1:0] edge_q;
  logic [DATA_W-1:0] edge_d;
  logic [DATA_W-1:0] ien_q;
  logic [DATA_W-1:0] ien_d;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;
  logic              rd_valid_q;
  logic              rd_valid_d;
  logic              addr_err_q;
  logic              addr_err_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [31:0]       addr_idx;
  logic              mapped;
  logic              wr_edge;
  logic              wr_ien;
  logic              primed;
  logic [DATA_W-1:0] rise;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] rd_sel;

  assign addr_idx = 32'(bus.addr);
  assign mapped   = (addr_idx < 32'(N_MAPPED));
  assign wr_edge  = bus.we && (addr_idx == 32'(EDGE_ADDR));
  assign wr_ien   = bus.we && (addr_idx == 32'(IEN_ADDR));
  assign primed   = (prime_q == 2'd3);

  // Synchroniser chain: two flops per port, plus a third on port 0 for edge detection.
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      s1_d[k] = gpi[k*DATA_W +: DATA_W];
      s2_d[k] = s1_q[k];
    end
    s3_d = s2_q[0];
  end

  // Prime counter: suppresses edges until the synchroniser holds post-reset data.
  always_comb begin
    prime_d = primed ? prime_q : prime_q + 2'd1;
  end

  // Output registers take bus writes aimed at their own address.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      gpo_d[j] = (bus.we && (addr_idx == 32'(N_IN + j))) ? bus.wd : gpo_q[j];
    end
  end

  // Sticky edge status (write-1-to-clear, a new rise beats a clear) and interrupt enable.
  always_comb begin
    rise   = s2_q[0] & ~s3_q & {DATA_W{primed}};
    clr    = wr_edge ? bus.wd : '0;
    edge_d = (edge_q & ~clr) | rise;
    ien_d  = wr_ien ? bus.wd : ien_q;
  end

  // Read mux: selects from pre-edge state, so a same-edge write is not yet visible.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned
    // and infers a latch; unmapped addresses fall through to this zero.
    rd_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (addr_idx == 32'(k)) rd_sel = s2_q[k];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (addr_idx == 32'(N_IN + j)) rd_sel = gpo_q[j];
    end
    if (addr_idx == 32'(EDGE_ADDR)) rd_sel = edge_q;
    if (addr_idx == 32'(IEN_ADDR))  rd_sel = ien_q;
  end

  // Read-data hold, valid strobe and unmapped-access error strobe.
  always_comb begin
    rd_d       = bus.re ? rd_sel : rd_q;
    rd_valid_d = bus.re;
    addr_err_d = (bus.we || bus.re) && !mapped;
  end

  // State register with synchronous reset; every flop, including the array
  // elements, returns to zero so reads after reset are deterministic.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values,
    // which is what makes the synchroniser chain and read-before-write behave.
    if (rst) begin
      for (int k = 0; k < N_IN; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        gpo_q[j] <= '0;
      end
      s3_q       <= '0;
      prime_q    <= '0;
      edge_q     <= '0;
      ien_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        s1_q[k] <= s1_d[k];
        s2_q[k] <= s2_d[k];
      end
      for (int j = 0; j < N_OUT; j++) begin
        gpo_q[j] <= gpo_d[j];
      end
      s3_q       <= s3_d;
      prime_q    <= prime_d;
      edge_q     <= edge_d;
      ien_q      <= ien_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < N_OUT; j++) begin : g_gpo
    assign gpo[j*DATA_W +: DATA_W] = gpo_q[j];
  end

  assign irq          = |(edge_q & ien_q);
  assign addr_err     = addr_err_q;
  assign bus.rd       = rd_q;
  assign bus.rd_valid = rd_valid_q;

endmodule : gpio_bank_ctrl

// File: tb/tb_gpio_bank_ctrl.sv
// Directed self-checking bench for gpio_bank_ctrl (default 2-in/2-out, 32-bit).
module tb_gpio_bank_ctrl;

  localparam int DATA_W = 32;
  localparam int N_IN   = 2;
  localparam int N_OUT  = 2;
  localparam int ADDR_W = 3;

  logic                    clk;
  logic                    rst;
  logic [N_IN*DATA_W-1:0]  gpi;
  logic [N_OUT*DATA_W-1:0] gpo;
  logic                    irq;
  logic                    addr_err;

  int checks = 0;
  int errors = 0;

  gpio_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  gpio_bank_ctrl #(
    .DATA_W(DATA_W),
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .gpi     (gpi),
    .gpo     (gpo),
    .irq     (irq),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus_if.addr = a;
    bus_if.wd   = d;
    bus_if.we   = 1'b1;
    tick();
    bus_if.we   = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a);
    bus_if.addr = a;
    bus_if.re   = 1'b1;
    tick();
    bus_if.re   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    gpi         = '0;
    bus_if.addr = '0;
    bus_if.we   = 1'b0;
    bus_if.re   = 1'b0;
    bus_if.wd   = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_gpo",      gpo,             64'h0);
    check("rst_rd",       bus_if.rd,       64'h0);
    check("rst_rd_valid", bus_if.rd_valid, 64'h0);
    check("rst_irq",      irq,             64'h0);
    check("rst_addr_err", addr_err,        64'h0);

    // Output register write and read-back
    bus_write(3'd2, 32'hDEADBEEF);
    check("out0_write", gpo[31:0], 64'hDEADBEEF);
    bus_read(3'd2);
    check("out0_rd",       bus_if.rd,       64'hDEADBEEF);
    check("out0_rd_valid", bus_if.rd_valid, 64'h1);
    tick();
    check("rd_valid_drop", bus_if.rd_valid, 64'h0);
    check("rd_hold",       bus_if.rd,       64'hDEADBEEF);
    bus_write(3'd3, 32'h0BADF00D);
    check("out1_write", gpo, 64'h0BADF00D_DEADBEEF);

    // Same-edge read and write to one address returns the pre-write value
    bus_if.addr = 3'd2;
    bus_if.wd   = 32'h11111111;
    bus_if.we   = 1'b1;
    bus_if.re   = 1'b1;
    tick();
    bus_if.we   = 1'b0;
    bus_if.re   = 1'b0;
    check("rw_same_rd",  bus_if.rd, 64'hDEADBEEF);
    check("rw_same_gpo", gpo[31:0], 64'h11111111);

    // Writes to an input port are ignored without an error
    bus_write(3'd0, 32'hFFFFFFFF);
    check("in_write_no_err", addr_err, 64'h0);
    bus_read(3'd0);
    check("in_write_ignored", bus_if.rd, 64'h0);

    // Synchroniser latency on port 1
    gpi[63:32] = 32'h12345678;
    bus_read(3'd1);
    check("sync_edge1", bus_if.rd, 64'h0);
    tick();
    bus_read(3'd1);
    check("sync_edge3", bus_if.rd, 64'h12345678);

    // Edge capture and interrupt on port 0 bit 0
    bus_write(3'd5, 32'h1);
    gpi[0] = 1'b1;
    tick();
    tick();
    check("irq_before_edge", irq, 64'h0);
    tick();
    check("irq_after_edge", irq, 64'h1);
    bus_read(3'd4);
    check("edge_rd", bus_if.rd, 64'h1);
    bus_write(3'd5, 32'h0);
    check("ien_mask_off", irq, 64'h0);
    bus_write(3'd5, 32'h1);
    check("ien_mask_on", irq, 64'h1);
    bus_write(3'd4, 32'h1);
    check("edge_clear_irq", irq, 64'h0);
    bus_read(3'd4);
    check("edge_clear_rd", bus_if.rd, 64'h0);

    // Clear coinciding with a new rise: the rise wins
    gpi[0] = 1'b0;
    tick();
    tick();
    tick();
    gpi[0] = 1'b1;
    tick();
    tick();
    bus_write(3'd4, 32'h1);
    check("set_wins_irq", irq, 64'h1);
    bus_read(3'd4);
    check("set_wins_rd", bus_if.rd, 64'h1);
    bus_write(3'd4, 32'h1);
    check("clear_after_set", irq, 64'h0);

    // Reset mid-operation drops a pending read; gpi[0] stays high through reset
    bus_if.addr = 3'd2;
    bus_if.re   = 1'b1;
    rst         = 1'b1;
    tick();
    bus_if.re   = 1'b0;
    check("rst_drop_valid", bus_if.rd_valid, 64'h0);
    check("rst_mid_rd",     bus_if.rd,       64'h0);
    check("rst_mid_gpo",    gpo,             64'h0);
    tick();
    rst = 1'b0;
    bus_write(3'd5, 32'h1);
    repeat (10) tick();
    check("held_high_irq", irq, 64'h0);
    bus_read(3'd4);
    check("held_high_edge", bus_if.rd, 64'h0);

    // Unmapped accesses
    bus_write(3'd2, 32'h55);
    bus_read(3'd2);
    check("pre_unmapped_rd", bus_if.rd, 64'h55);
    bus_write(3'd6, 32'hFFFFFFFF);
    check("unmapped_wr_err", addr_err, 64'h1);
    check("unmapped_wr_gpo", gpo,      64'h55);
    tick();
    check("addr_err_pulse", addr_err, 64'h0);
    bus_read(3'd7);
    check("unmapped_rd_err",   addr_err,        64'h1);
    check("unmapped_rd",       bus_if.rd,       64'h0);
    check("unmapped_rd_valid", bus_if.rd_valid, 64'h1);
    bus_read(3'd5);
    check("ien_unchanged", bus_if.rd, 64'h1);
    check("ien_rd_no_err", addr_err,  64'h0);
    bus_read(3'd4);
    check("edge_unchanged", bus_if.rd, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpio_bank_ctrl
